// File: rtl/vdp_super_res_vram_arbiter.sv
// Slot-based arbiter sharing one 32-bit SDRAM port between the super-high-res video fetcher,
// the CPU port and the command engine. Video has priority; CPU and CMD alternate in free slots.
module vdp_super_res_vram_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slot_sync,
    input  logic        video_en,
    input  logic        video_req,
    input  logic [16:0] video_addr,
    output logic [31:0] video_data,
    output logic        video_valid,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [16:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wmask,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    input  logic [16:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wmask,
    output logic        cmd_ack,
    output logic [31:0] cmd_rdata,
    output logic [16:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  cpu_starve
);

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned SW = 8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_CMD  = 2'd3;

    if (MEM_LAT < 1 || MEM_LAT > 2) begin : g_bad_mem_lat
        $error("vdp_super_res_vram_arbiter: MEM_LAT must be 1 or 2");
    end

    logic [1:0]     r_phase;
    logic           r_rr_last_cmd;
    logic [MEM_LAT:0] r_pipe_vld;
    logic [MEM_LAT:0] r_pipe_wr;
    logic [1:0]     r_pipe_own [0:MEM_LAT];

    logic           w_arb;
    logic           w_cpu_busy;
    logic           w_cmd_busy;
    logic           w_cpu_pend;
    logic           w_cmd_pend;
    logic [1:0]     w_win;
    logic [AW-1:0]  w_sel_addr;
    logic           w_sel_wr;
    logic [DW-1:0]  w_sel_wdata;
    logic [MW-1:0]  w_sel_wmask;
    logic           w_cap;
    logic [1:0]     w_cap_own;
    logic           w_cap_wr;

    // Slot phase: free-running, slot_sync realigns so the next cycle is phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= 2'd0;
        end else if (slot_sync) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    assign w_arb     = (r_phase == 2'd0);
    assign w_cap     = r_pipe_vld[MEM_LAT];
    assign w_cap_own = r_pipe_own[MEM_LAT];
    assign w_cap_wr  = r_pipe_wr[MEM_LAT];

    // A requester with an access in flight or being acked must not be granted its held request again.
    always_comb begin
        w_cpu_busy = cpu_ack;
        w_cmd_busy = cmd_ack;
        for (int unsigned i = 0; i <= MEM_LAT; i++) begin
            if (r_pipe_vld[i] && (r_pipe_own[i] == OWN_CPU)) w_cpu_busy = 1'b1;
            if (r_pipe_vld[i] && (r_pipe_own[i] == OWN_CMD)) w_cmd_busy = 1'b1;
        end
    end

    assign w_cpu_pend = cpu_req & ~w_cpu_busy;
    assign w_cmd_pend = cmd_req & ~w_cmd_busy;

    always_comb begin
        w_win = OWN_NONE;
        if (w_arb) begin
            if (video_en && video_req) begin
                w_win = OWN_VID;
            end else if (w_cpu_pend && w_cmd_pend) begin
                w_win = r_rr_last_cmd ? OWN_CPU : OWN_CMD;
            end else if (w_cpu_pend) begin
                w_win = OWN_CPU;
            end else if (w_cmd_pend) begin
                w_win = OWN_CMD;
            end
        end
    end

    always_comb begin
        w_sel_addr  = video_addr;
        w_sel_wr    = 1'b0;
        w_sel_wdata = cpu_wdata;
        w_sel_wmask = cpu_wmask;
        case (w_win)
            OWN_CPU: begin
                w_sel_addr = cpu_addr;
                w_sel_wr   = cpu_wr;
            end
            OWN_CMD: begin
                w_sel_addr  = cmd_addr;
                w_sel_wr    = cmd_wr;
                w_sel_wdata = cmd_wdata;
                w_sel_wmask = cmd_wmask;
            end
            default: ;
        endcase
    end

    // In-flight tracker: stage 0 is the strobe cycle, stage MEM_LAT is the capture cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_vld <= '0;
            r_pipe_wr  <= '0;
            for (int unsigned i = 0; i <= MEM_LAT; i++) begin
                r_pipe_own[i] <= OWN_NONE;
            end
        end else begin
            r_pipe_vld[0] <= (w_win != OWN_NONE);
            r_pipe_wr[0]  <= w_sel_wr;
            r_pipe_own[0] <= w_win;
            for (int unsigned i = 1; i <= MEM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_wr[i]  <= r_pipe_wr[i-1];
                r_pipe_own[i] <= r_pipe_own[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last_cmd <= 1'b1;
            cpu_starve    <= '0;
        end else if (w_arb) begin
            if (w_win == OWN_CPU) r_rr_last_cmd <= 1'b0;
            if (w_win == OWN_CMD) r_rr_last_cmd <= 1'b1;
            if (cpu_req && (w_win != OWN_CPU)) begin
                if (cpu_starve != SW'(255)) cpu_starve <= cpu_starve + SW'(1);
            end else begin
                cpu_starve <= '0;
            end
        end
    end

    // Memory command outputs; address and write payload hold their last values when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (w_win != OWN_NONE) begin
                mem_addr <= w_sel_addr;
                mem_rd   <= ~w_sel_wr;
                mem_wr   <= w_sel_wr;
                if (w_win != OWN_VID) begin
                    mem_wdata <= w_sel_wdata;
                    mem_wmask <= w_sel_wmask;
                end
            end
        end
    end

    // Return path: data captured at the end of the capture cycle, presented one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_data  <= '0;
            video_valid <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            cmd_ack     <= 1'b0;
            cmd_rdata   <= '0;
        end else begin
            video_valid <= w_cap && (w_cap_own == OWN_VID);
            cpu_ack     <= w_cap && (w_cap_own == OWN_CPU);
            cmd_ack     <= w_cap && (w_cap_own == OWN_CMD);
            if (w_cap && (w_cap_own == OWN_VID)) video_data <= mem_rdata;
            if (w_cap && (w_cap_own == OWN_CPU) && !w_cap_wr) cpu_rdata <= mem_rdata;
            if (w_cap && (w_cap_own == OWN_CMD) && !w_cap_wr) cmd_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vdp_super_res_vram_arbiter.sv
// Directed bench for vdp_super_res_vram_arbiter (MEM_LAT = 2): video priority, starvation count,
// round-robin, writes, reset abandonment and mid-slot resync.
module tb_vdp_super_res_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        slot_sync = 1'b0;
    logic        video_en = 1'b0;
    logic        video_req = 1'b0;
    logic [16:0] video_addr = '0;
    logic [31:0] video_data;
    logic        video_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wmask = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cmd_req = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [16:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        cmd_ack;
    logic [31:0] cmd_rdata;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  cpu_starve;

    int tests = 0;
    int fails = 0;
    int n_cpu_ack = 0;
    int n_cmd_ack = 0;
    int n_mem_wr = 0;
    int base_ack;
    int base_wr;

    always #5 clk = ~clk;

    vdp_super_res_vram_arbiter #(.MEM_LAT(2)) dut (
        .clk(clk), .reset(reset), .slot_sync(slot_sync),
        .video_en(video_en), .video_req(video_req), .video_addr(video_addr),
        .video_data(video_data), .video_valid(video_valid),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wmask(cmd_wmask), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .cpu_starve(cpu_starve)
    );

    // Advance one cycle and sample just after the edge; tallies strobes and acks.
    task automatic tick();
        @(posedge clk);
        #1;
        n_cpu_ack += int'(cpu_ack);
        n_cmd_ack += int'(cmd_ack);
        n_mem_wr  += int'(mem_wr);
    endtask

    task automatic slot();
        repeat (4) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_video_valid", 32'(video_valid), 32'd0);
        chk("rst_cpu_starve", 32'(cpu_starve), 32'd0);

        // 1: video read after slot_sync
        reset = 1'b0;
        slot_sync = 1'b1;
        tick();
        slot_sync = 1'b0;
        video_en = 1'b1;
        video_req = 1'b1;
        video_addr = 17'h00010;
        tick();
        chk("t1_mem_rd", 32'(mem_rd), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h00010);
        video_req = 1'b0;
        tick();
        tick();
        mem_rdata = 32'h00AABBCC;
        chk("t1_valid_early", 32'(video_valid), 32'd0);
        tick();
        chk("t1_video_valid", 32'(video_valid), 32'd1);
        chk("t1_video_data", video_data, 32'h00AABBCC);

        // 2: CPU starved by continuous video for 10 slots
        mem_rdata = 32'hCAFE0000;
        video_req = 1'b1;
        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 17'h00123;
        base_ack = n_cpu_ack;
        repeat (10) slot();
        chk("t2_starve10", 32'(cpu_starve), 32'd10);
        chk("t2_no_ack", 32'(n_cpu_ack - base_ack), 32'd0);
        video_req = 1'b0;
        tick();
        chk("t2_starve_clr", 32'(cpu_starve), 32'd0);
        chk("t2_cpu_rd", 32'(mem_rd), 32'd1);
        chk("t2_cpu_addr", 32'(mem_addr), 32'h00123);
        tick();
        tick();
        mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t2_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0;
        slot();

        // 3: round robin; last grant was CPU so CMD goes first
        cpu_req = 1'b1;
        cpu_addr = 17'h00AAA;
        cmd_req = 1'b1;
        cmd_wr = 1'b0;
        cmd_addr = 17'h00BBB;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_rd", 32'(mem_rd), 32'd1);
            chk("t3_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h00BBB : 32'h00AAA);
            tick();
            tick();
            mem_rdata = 32'h10000000 + 32'(k);
            tick();
            chk("t3_cmd_ack", 32'(cmd_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_cpu_ack", 32'(cpu_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k % 2 == 0) chk("t3_cmd_rdata", cmd_rdata, 32'h10000000 + 32'(k));
            else            chk("t3_cpu_rdata", cpu_rdata, 32'h10000000 + 32'(k));
        end
        cpu_req = 1'b0;
        cmd_req = 1'b0;
        slot();

        // 4: CPU write at top address; req held through the ack cycle
        cpu_req = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = 17'h1FFFF;
        cpu_wdata = 32'h12345678;
        cpu_wmask = 4'b0101;
        base_ack = n_cpu_ack;
        base_wr = n_mem_wr;
        tick();
        chk("t4_mem_wr", 32'(mem_wr), 32'd1);
        chk("t4_mem_rd", 32'(mem_rd), 32'd0);
        chk("t4_addr", 32'(mem_addr), 32'h1FFFF);
        chk("t4_wdata", mem_wdata, 32'h12345678);
        chk("t4_wmask", 32'(mem_wmask), 32'h5);
        tick();
        tick();
        tick();
        chk("t4_ack", 32'(cpu_ack), 32'd1);
        chk("t4_rdata_hold", cpu_rdata, 32'h10000003);
        tick();
        chk("t4_no_regrant_wr", 32'(mem_wr), 32'd0);
        chk("t4_no_regrant_rd", 32'(mem_rd), 32'd0);
        chk("t4_starve1", 32'(cpu_starve), 32'd1);
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_one_wr", 32'(n_mem_wr - base_wr), 32'd1);
        chk("t4_one_ack", 32'(n_cpu_ack - base_ack), 32'd1);

        // 5: reset during phase 2 of a CPU read abandons it
        cpu_req = 1'b1;
        cpu_addr = 17'h00055;
        base_ack = n_cpu_ack;
        tick();
        chk("t5_rd", 32'(mem_rd), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_addr", 32'(mem_addr), 32'd0);
        chk("t5_rst_rdata", cpu_rdata, 32'd0);
        chk("t5_rst_vdata", video_data, 32'd0);
        chk("t5_rst_wdata", mem_wdata, 32'd0);
        cpu_req = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        tick();
        reset = 1'b0;
        slot_sync = 1'b1;
        tick();
        slot_sync = 1'b0;
        chk("t5_no_ack", 32'(n_cpu_ack - base_ack), 32'd0);
        cpu_req = 1'b1;
        tick();
        chk("t5_rerd", 32'(mem_rd), 32'd1);
        chk("t5_readdr", 32'(mem_addr), 32'h00055);
        tick();
        tick();
        mem_rdata = 32'h5555AAAA;
        tick();
        chk("t5_ack", 32'(cpu_ack), 32'd1);
        chk("t5_rdata", cpu_rdata, 32'h5555AAAA);
        chk("t5_ack_count", 32'(n_cpu_ack - base_ack), 32'd1);
        cpu_req = 1'b0;

        // 6: slot_sync in the strobe cycle of a video read
        video_req = 1'b1;
        video_addr = 17'h00777;
        tick();
        chk("t6_rd1", 32'(mem_rd), 32'd1);
        chk("t6_addr1", 32'(mem_addr), 32'h00777);
        slot_sync = 1'b1;
        video_addr = 17'h00778;
        tick();
        slot_sync = 1'b0;
        chk("t6_gap_rd", 32'(mem_rd), 32'd0);
        chk("t6_gap_valid", 32'(video_valid), 32'd0);
        tick();
        chk("t6_rd2", 32'(mem_rd), 32'd1);
        chk("t6_addr2", 32'(mem_addr), 32'h00778);
        mem_rdata = 32'h11111111;
        video_req = 1'b0;
        tick();
        chk("t6_valid1", 32'(video_valid), 32'd1);
        chk("t6_data1", video_data, 32'h11111111);
        tick();
        chk("t6_valid_gap", 32'(video_valid), 32'd0);
        mem_rdata = 32'h22222222;
        tick();
        chk("t6_valid2", 32'(video_valid), 32'd1);
        chk("t6_data2", video_data, 32'h22222222);
        tick();
        chk("t6_idle_rd", 32'(mem_rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
